// File: rtl/program_loader.sv
// program_loader: length-prefixed byte stream to 32-bit instruction-memory writes, holds the core until loaded.
// Optional trailing XOR checksum with ERROR lock-up when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {LEN, DATA, WRITE, DONE, CSUM, ERROR} state_t;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state_q, state_d;
  logic [7:0] n_q, n_d, idx_q, idx_d;
  logic [1:0] k_q, k_d;
  logic [31:0] wdata_q, wdata_d;
  logic ready_q, ready_d, xfer;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    idx_d = idx_q;
    k_d = k_q;
    wdata_d = wdata_q;
    xfer = in_valid & ready_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d = xfer ? csum_q ^ in_data : csum_q;
`endif
    case (state_q)
      LEN: if (xfer) begin
        n_d = in_data;
        idx_d = '0;
        k_d = '0;
        state_d = (in_data == 8'd0) ? FIN : DATA;
      end
      DATA: if (xfer) begin
        wdata_d[8*k_q +: 8] = in_data;
        k_d = k_q + 2'd1;
        state_d = (k_q == 2'd3) ? WRITE : DATA;
      end
      WRITE: begin
        idx_d = idx_q + 8'd1;
        state_d = (idx_q + 8'd1 == n_q) ? FIN : DATA;
      end
      DONE: if (reload) begin
        state_d = LEN;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d = '0;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CSUM: if (xfer) state_d = (in_data == csum_q) ? DONE : ERROR;
`endif
      default: state_d = state_q;
    endcase
    // ready is registered from the next state so it never depends combinationally on inputs
    ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LEN;
      n_q <= '0;
      idx_q <= '0;
      k_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      idx_q <= idx_d;
      k_q <= k_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  assign in_ready = ready_q;
  assign im_we = state_q == WRITE;
  assign im_addr = BASE_ADDR + ADDR_W'(idx_q);
  assign im_wdata = wdata_q;
  assign cpu_hold = state_q != DONE;
  assign done = state_q == DONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign error = state_q == ERROR;
`else
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed streams into two loaders (base 0x00 and 0xFE) checked against a word-list model.
module tb_program_loader;
  logic clk = 0, rst = 1, in_valid = 0, reload = 0;
  logic [7:0] in_data = 0;
  logic ready0, we0, hold0, done0, err0, ready1, we1, hold1, done1, err1;
  logic [7:0] addr0, addr1;
  logic [31:0] wd0, wd1;
  int cyc = 0, n_chk = 0, n_pass = 0, e;
  logic [39:0] act0[$], act1[$], exp0[$], exp1[$];
  logic [7:0] d[$];

  program_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ready0),
    .reload(reload), .im_we(we0), .im_addr(addr0), .im_wdata(wd0),
    .cpu_hold(hold0), .done(done0), .error(err0));
  program_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ready1),
    .reload(reload), .im_we(we1), .im_addr(addr1), .im_wdata(wd1),
    .cpu_hold(hold1), .done(done1), .error(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst && we0) act0.push_back({addr0, wd0});
    if (rst && we1) act1.push_back({addr1, wd1});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'({ready0, ready1}), 64'(0));
    chk({tag, "_we"}, 64'({we0, we1}), 64'(0));
    chk({tag, "_addr0"}, 64'(addr0), 64'h00);
    chk({tag, "_addr1"}, 64'(addr1), 64'hFE);
    chk({tag, "_wdata"}, 64'({wd0, wd1}), 64'(0));
    chk({tag, "_hold"}, 64'({hold0, hold1}), 64'(3));
    chk({tag, "_done_err"}, 64'({done0, done1, err0, err1}), 64'(0));
  endtask

  // Presents one byte and returns the clock edge number on which it is accepted.
  task automatic send(input logic [7:0] b, output int edge_n);
    int t = 0;
    in_valid = 1;
    in_data = b;
    while (!ready0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", 64'(ready0), 64'(1));
    edge_n = cyc + 1;
    @(negedge clk);
    in_valid = 0;
    in_data = 8'($urandom);
  endtask

  task automatic run_load(input int n, input bit rnd, input int gap_at, input int gap_len,
                          input bit hold_rel, input string tag);
    int first, g, gt = 0, t = 0;
    logic [7:0] cs;
    logic [31:0] w;
    if (done0) begin
      reload = 1;
      @(negedge clk);
      reload = 0;
      chk({tag, "_reload_done"}, 64'(done0), 64'(0));
      chk({tag, "_reload_hold"}, 64'(hold0), 64'(1));
      chk({tag, "_reload_ready"}, 64'(ready0), 64'(1));
    end
    act0.delete(); act1.delete(); exp0.delete(); exp1.delete();
    for (int i = 0; i < n; i++) begin
      w = {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]};
      exp0.push_back({8'(i), w});
      exp1.push_back({8'((254 + i) % 256), w});
    end
    reload = hold_rel;
    cs = 8'(n);
    send(8'(n), first);
    if (n > 0) chk({tag, "_hold_mid"}, 64'({hold0, hold1, done0}), 64'(6));
    for (int i = 0; i < 4 * n; i++) begin
      send(d[i], e);
      cs ^= d[i];
      g = (i % 4 == 3) ? 0 : rnd ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0)
                                 : (i == gap_at ? gap_len : 0);
      repeat (g) @(negedge clk);
      gt += g;
    end
    reload = 0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(cs, e);
    gt += 1;
`endif
    while (!done0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_latency"}, 64'(cyc - first), 64'(5 * n + gt));
    chk({tag, "_done"}, 64'({done0, done1}), 64'(3));
    chk({tag, "_released"}, 64'({hold0, hold1, ready0, err0, we0}), 64'(0));
    chk({tag, "_nwrites0"}, 64'(act0.size()), 64'(n));
    chk({tag, "_nwrites1"}, 64'(act1.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_w0"}, 64'((i < act0.size()) ? act0[i] : 40'hx), 64'(exp0[i]));
      chk({tag, "_w1"}, 64'((i < act1.size()) ? act1[i] : 40'hx), 64'(exp1[i]));
    end
  endtask

  initial begin
    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1;
    chk("ready_at_release", 64'(ready0), 64'(0));
    @(negedge clk);
    chk("ready_first_cycle", 64'(ready0), 64'(1));

    d = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, -1, 0, 0, "prog2");
    chk("prog2_word0", 64'(act0[0]), 64'h00_0050_0013);
    chk("prog2_word1", 64'(act0[1]), 64'h01_0010_0093);
    run_load(2, 0, 1, 3, 0, "stall");

    d.delete();
    run_load(0, 0, -1, 0, 1, "empty");

    d.delete();
    repeat (12) d.push_back(8'($urandom));
    run_load(3, 0, -1, 0, 0, "wrap");
    chk("wrap_addr_last", 64'(act1[2][39:32]), 64'h00);

    for (int k = 0; k < 6; k++) begin
      d.delete();
      repeat (4 * 16) d.push_back(8'($urandom));
      run_load(int'($urandom_range(1, 16)), 1, -1, 0, k[0], "rnd");
    end

    reload = 1;
    @(negedge clk);
    reload = 0;
    act0.delete();
    d.delete();
    repeat (12) d.push_back(8'($urandom));
    send(8'd3, e);
    for (int i = 0; i < 6; i++) send(d[i], e);
    chk("abort_hold_before", 64'(hold0), 64'(1));
    rst = 0;
    #1 chk_reset("abort");
    chk("abort_kept_writes", 64'(act0.size()), 64'(1));
    chk("abort_word0", 64'(act0[0]), 64'({8'h00, d[3], d[2], d[1], d[0]}));
    @(negedge clk);
    chk("abort_hold_during", 64'(hold0), 64'(1));
    rst = 1;
    @(negedge clk);
    chk("abort_ready_after", 64'(ready0), 64'(1));
    d.delete();
    repeat (4) d.push_back(8'($urandom));
    run_load(1, 0, -1, 0, 0, "after_abort");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(1, 0, -1, 0, 0, "csum_good");
    reload = 1;
    @(negedge clk);
    reload = 0;
    send(8'd1, e);
    for (int i = 0; i < 4; i++) send(d[i], e);
    send(8'h00, e);
    repeat (3) @(negedge clk);
    chk("csum_bad_state", 64'({err0, hold0, ready0, done0}), 64'b1100);
    reload = 1;
    @(negedge clk);
    reload = 0;
    @(negedge clk);
    chk("csum_bad_reload_ignored", 64'({err0, hold0, ready0, done0}), 64'b1100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
